// File: rtl/banked_inst_mem.sv
// Writable, banked instruction memory with a registered fetch port, a run-time loader
// port and a post-reset FILL sweep. Define INSTMEM_LOCK_EN to enable per-bank write protect.
module banked_inst_mem #(
    parameter int                DATA_W = 8,
    parameter int                ADDR_W = 8,
    parameter int                BANKS  = 4,
    parameter int                BANK_W = 2,
    parameter logic [DATA_W-1:0] FILL   = 8'hFF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [BANK_W-1:0] bank_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic              fetch_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    output logic              busy_o,
    input  logic              load_valid_i,
    input  logic [BANK_W-1:0] load_bank_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              load_ready_o,
    input  logic [BANKS-1:0]  lock_i,
    output logic              load_err_o
);

    localparam int               DEPTH = 2 ** ADDR_W;
    localparam int               CNT_W = BANK_W + ADDR_W;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BANKS * DEPTH - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  sweep_cnt;

    // NOTE: the array has no reset branch; clearing it is the job of the INIT sweep,
    // which keeps it mappable onto plain RAM without per-word reset logic.
    logic [DATA_W-1:0] mem [BANKS][DEPTH];

    logic              fetch_bank_ok;
    logic              load_bank_ok;
    logic              load_ok;
    logic              mem_we;
    logic [BANK_W-1:0] mem_wbank;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign busy_o        = (state == INIT);
    assign load_ready_o  = (state == RUN);
    assign fetch_bank_ok = int'(bank_i) < BANKS;
    assign load_bank_ok  = int'(load_bank_i) < BANKS;

`ifdef INSTMEM_LOCK_EN
    // A locked bank rejects the write exactly like an invalid bank does.
    assign load_ok = load_bank_ok && !lock_i[load_bank_i];
`else
    logic unused_lock;
    assign unused_lock = ^lock_i;
    assign load_ok     = load_bank_ok;
`endif

    // Single write port shared by the sweep (INIT) and the loader (RUN).
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        mem_we    = 1'b0;
        mem_wbank = load_bank_i;
        mem_waddr = load_addr_i;
        mem_wdata = load_data_i;
        if (!reset_i) begin
            if (state == INIT) begin
                mem_we    = 1'b1;
                mem_wbank = sweep_cnt[CNT_W-1:ADDR_W];
                mem_waddr = sweep_cnt[ADDR_W-1:0];
                mem_wdata = FILL;
            end else if (load_valid_i && load_ok) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_wbank][mem_waddr] <= mem_wdata;
        end
    end

    // NOTE: non-blocking assignments here make the fetch sample the word before a
    // same-edge loader write lands, which is exactly the read-before-write behaviour.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state        <= INIT;
            sweep_cnt    <= '0;
            data_o       <= FILL;
            data_valid_o <= 1'b0;
            load_err_o   <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            load_err_o   <= 1'b0;
            case (state)
                INIT: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == LAST) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (fetch_i) begin
                        data_valid_o <= 1'b1;
                        data_o       <= fetch_bank_ok ? mem[bank_i][address_i] : FILL;
                    end
                    if (load_valid_i && !load_ok) begin
                        load_err_o <= 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule
